// File: rtl/hpu_pkg.sv
// Shared types for the host-processing-unit output path: result/beat widths,
// the FIFO beat record and the packer state encoding.
package hpu_pkg;

    localparam int RES_W  = 32;
    localparam int BEAT_W = 64;

    typedef struct packed {
        logic              last;
        logic [BEAT_W-1:0] data;
    } beat_t;

    typedef enum logic {
        PK_LOW  = 1'b0,
        PK_HIGH = 1'b1
    } pack_state_t;

    // The first result of a pair always lands in the low half of the beat.
    function automatic beat_t make_beat(input logic [RES_W-1:0] hi,
                                        input logic [RES_W-1:0] lo,
                                        input logic             last);
        beat_t b;
        b.last = last;
        b.data = {hi, lo};
        return b;
    endfunction

endpackage

// File: rtl/beat_fifo.sv
// Synchronous FIFO with a registered show-ahead head; occupancy counts the
// stored entries plus the head register.
module beat_fifo #(
    parameter  int WIDTH = 65,
    parameter  int DEPTH = 32,
    localparam int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_head_valid,
    output logic [WIDTH-1:0] o_head_data,
    output logic [OCC_W-1:0] o_occupancy
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [OCC_W-1:0] r_mem_cnt;
    logic [OCC_W-1:0] r_occ;
    logic             r_head_valid;
    logic [WIDTH-1:0] r_head_data;

    logic w_pop;
    logic w_load;

    assign w_pop  = i_pop & r_head_valid;
    // A push only becomes visible at the head one edge later, never bypassed.
    assign w_load = (~r_head_valid | w_pop) & (r_mem_cnt != '0);

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_mem_cnt    <= '0;
            r_occ        <= '0;
            r_head_valid <= 1'b0;
            r_head_data  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_rd_ptr     <= r_rd_ptr + 1'b1;
                r_head_data  <= r_mem[r_rd_ptr];
                r_head_valid <= 1'b1;
            end else if (w_pop) begin
                r_head_valid <= 1'b0;
            end
            case ({i_push, w_load})
                2'b10:   r_mem_cnt <= r_mem_cnt + 1'b1;
                2'b01:   r_mem_cnt <= r_mem_cnt - 1'b1;
                default: r_mem_cnt <= r_mem_cnt;
            endcase
            case ({i_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_head_valid = r_head_valid;
    assign o_head_data  = r_head_data;
    assign o_occupancy  = r_occ;

endmodule

// File: rtl/result_packer.sv
// Packs 32-bit core results pairwise into 64-bit AXI-Stream beats, buffers them,
// and drives them out with valid/ready; tracks overflow and emitted beats.
module result_packer
    import hpu_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [RES_W-1:0]         in_data,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [BEAT_W-1:0]        out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     overflow,
    output logic [CNT_W-1:0]         beat_count,
    output pack_state_t              o_dbg_state,
    output logic [$clog2(DEPTH):0]   o_dbg_occupancy
);

    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    pack_state_t      r_state;
    logic [RES_W-1:0] r_low_hold;
    logic             r_overflow;
    logic [CNT_W-1:0] r_beat_count;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_push;
    logic             w_out_fire;
    beat_t            w_push_beat;
    beat_t            w_head;
    logic             w_head_valid;
    logic [OCC_W-1:0] w_occ;

    // Ready looks only at registered occupancy, so a pop at full does not
    // reopen the input until the following cycle.
    assign w_in_ready = (w_occ < FULL_OCC);
    assign w_accept   = in_valid & w_in_ready;
    assign w_push     = w_accept & ((r_state == PK_HIGH) | in_last);
    assign w_out_fire = w_head_valid & out_ready;

    always_comb begin
        w_push_beat = '0;
        if (r_state == PK_HIGH) begin
            w_push_beat = make_beat(in_data, r_low_hold, in_last);
        end else begin
            w_push_beat = make_beat('0, in_data, 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= PK_LOW;
            r_low_hold   <= '0;
            r_overflow   <= 1'b0;
            r_beat_count <= '0;
        end else begin
            if (in_valid & ~w_in_ready) begin
                r_overflow <= 1'b1;
            end
            if (w_out_fire) begin
                r_beat_count <= r_beat_count + 1'b1;
            end
            if (w_accept) begin
                case (r_state)
                    PK_LOW: begin
                        if (!in_last) begin
                            r_low_hold <= in_data;
                            r_state    <= PK_HIGH;
                        end
                    end
                    PK_HIGH: begin
                        r_state <= PK_LOW;
                    end
                    default: r_state <= PK_LOW;
                endcase
            end
        end
    end

    beat_fifo #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_data  (w_push_beat),
        .i_pop        (out_ready),
        .o_head_valid (w_head_valid),
        .o_head_data  (w_head),
        .o_occupancy  (w_occ)
    );

    assign in_ready        = w_in_ready;
    assign out_valid       = w_head_valid;
    assign out_data        = w_head.data;
    assign out_last        = w_head.last;
    assign overflow        = r_overflow;
    assign beat_count      = r_beat_count;
    assign o_dbg_state     = r_state;
    assign o_dbg_occupancy = w_occ;

endmodule

// File: tb/tb_result_packer.sv
// Directed bench for result_packer: pairing, latency, full/overflow, random
// back-pressure with stall stability, mid-job reset and push+pop at DEPTH-1.
module tb_result_packer;
    import hpu_pkg::*;

    localparam int DEPTH = 32;
    localparam int CNT_W = 16;

    // Handshake: a beat moves on an edge where out_valid & out_ready were both
    // high; a result moves on an edge where in_valid & in_ready were both high.

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [31:0]       in_data;
    logic              in_last;
    logic              in_ready;
    logic              out_valid;
    logic [63:0]       out_data;
    logic              out_last;
    logic              out_ready;
    logic              overflow;
    logic [CNT_W-1:0]  beat_count;
    pack_state_t       dbg_state;
    logic [5:0]        dbg_occupancy;

    int                n_checks = 0;
    int                n_errors = 0;
    logic [64:0]       exp_q[$];
    bit                rand_ready = 1'b0;
    bit                stall_pending = 1'b0;
    logic [64:0]       held = '0;

    result_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_last         (in_last),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_last        (out_last),
        .out_ready       (out_ready),
        .overflow        (overflow),
        .beat_count      (beat_count),
        .o_dbg_state     (dbg_state),
        .o_dbg_occupancy (dbg_occupancy)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock step; inputs are driven and outputs sampled 1ns after posedge.
    task automatic cycle();
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        if (stall_pending) begin
            check("stall_valid", 65'(out_valid), 65'd1);
            check("stall_data", {out_last, out_data}, held);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_beat", 65'(out_valid & out_ready), 65'd0);
            else check("beat", {out_last, out_data}, exp_q.pop_front());
        end
        stall_pending = out_valid & ~out_ready & ~rst;
        held = {out_last, out_data};
        @(posedge clk);
        #1;
    endtask

    // Source that obeys in_ready: in_valid is only raised while in_ready is high.
    task automatic send(input logic [31:0] d, input logic l);
        int w;
        in_data = d;
        in_last = l;
        w = 0;
        while (!in_ready && w < 1000) begin
            in_valid = 1'b0;
            cycle();
            w++;
        end
        if (!in_ready) begin
            check("send_timeout", 65'(in_ready), 65'd1);
        end else begin
            in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 500) begin
            cycle();
            w++;
        end
        check("drain_left", 65'(exp_q.size()), 65'd0);
        check("drain_idle", 65'(out_valid), 65'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;

        check("rst_out_valid", 65'(out_valid), 65'd0);
        check("rst_out_data", 65'(out_data), 65'd0);
        check("rst_out_last", 65'(out_last), 65'd0);
        check("rst_in_ready", 65'(in_ready), 65'd1);
        check("rst_overflow", 65'(overflow), 65'd0);
        check("rst_beat_count", 65'(beat_count), 65'd0);
        check("rst_state", 65'(dbg_state), 65'(PK_LOW));
        check("rst_occ", 65'(dbg_occupancy), 65'd0);

        // 1,2,3,4 with last on 4; also latency of the first completed pair
        out_ready = 1'b1;
        exp_q.push_back({1'b0, 64'h00000002_00000001});
        exp_q.push_back({1'b1, 64'h00000004_00000003});
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        check("lat_edge", 65'(out_valid), 65'd0);
        cycle();
        check("lat_edge_plus1", 65'(out_valid), 65'd1);
        send(32'd3, 1'b0);
        send(32'd4, 1'b1);
        drain();
        check("beat_count_2", 65'(beat_count), 65'd2);

        // odd-length job: last result goes out alone in the low half
        exp_q.push_back({1'b0, 64'h00000006_00000005});
        exp_q.push_back({1'b1, 64'h00000000_00000007});
        send(32'd5, 1'b0);
        send(32'd6, 1'b0);
        send(32'd7, 1'b1);
        drain();
        check("beat_count_4", 65'(beat_count), 65'd4);

        // fill to DEPTH beats with the sink stalled
        out_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++)
            exp_q.push_back({1'(k == DEPTH - 1), 32'(101 + 2 * k), 32'(100 + 2 * k)});
        for (int i = 0; i < 2 * DEPTH; i++)
            send(32'(100 + i), 1'(i == 2 * DEPTH - 1));
        check("full_in_ready", 65'(in_ready), 65'd0);
        check("full_occ", 65'(dbg_occupancy), 65'(DEPTH));
        check("full_no_overflow", 65'(overflow), 65'd0);
        in_valid = 1'b1; in_data = 32'hDEADBEEF; in_last = 1'b0;
        cycle();
        in_valid = 1'b0;
        check("overflow_set", 65'(overflow), 65'd1);
        check("overflow_state", 65'(dbg_state), 65'(PK_LOW));
        check("overflow_occ", 65'(dbg_occupancy), 65'(DEPTH));
        out_ready = 1'b1;
        check("full_pop_ready", 65'(in_ready), 65'd0);
        cycle();
        check("ready_after_pop", 65'(in_ready), 65'd1);
        check("occ_after_pop", 65'(dbg_occupancy), 65'(DEPTH - 1));
        drain();
        check("beat_count_36", 65'(beat_count), 65'd36);

        // random 50% back-pressure over 100 results
        rand_ready = 1'b1;
        for (int k = 0; k < 50; k++)
            exp_q.push_back({1'(k == 49), 32'(1001 + 2 * k), 32'(1000 + 2 * k)});
        for (int i = 0; i < 100; i++)
            send(32'(1000 + i), 1'(i == 99));
        drain();
        rand_ready = 1'b0;
        out_ready = 1'b1;
        check("beat_count_86", 65'(beat_count), 65'd86);

        // reset while holding a low half with 3 beats buffered
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++)
            send(32'(i + 1), 1'b0);
        check("pre_rst_state", 65'(dbg_state), 65'(PK_HIGH));
        check("pre_rst_occ", 65'(dbg_occupancy), 65'd3);
        check("pre_rst_valid", 65'(out_valid), 65'd1);
        rst = 1'b1;
        exp_q.delete();
        cycle();
        check("mid_rst_valid", 65'(out_valid), 65'd0);
        check("mid_rst_beat_count", 65'(beat_count), 65'd0);
        check("mid_rst_state", 65'(dbg_state), 65'(PK_LOW));
        check("mid_rst_occ", 65'(dbg_occupancy), 65'd0);
        check("mid_rst_overflow", 65'(overflow), 65'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        exp_q.push_back({1'b1, 64'h0000000A_00000009});
        send(32'd9, 1'b0);
        send(32'd10, 1'b1);
        drain();
        check("beat_count_after_rst", 65'(beat_count), 65'd1);

        // simultaneous push and pop at DEPTH-1
        out_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++)
            exp_q.push_back({1'(k == DEPTH - 1), 32'(2001 + 2 * k), 32'(2000 + 2 * k)});
        for (int i = 0; i < 2 * DEPTH - 1; i++)
            send(32'(2000 + i), 1'b0);
        check("pp_pre_occ", 65'(dbg_occupancy), 65'(DEPTH - 1));
        check("pp_pre_ready", 65'(in_ready), 65'd1);
        out_ready = 1'b1;
        send(32'(2000 + 2 * DEPTH - 1), 1'b1);
        check("pp_occ", 65'(dbg_occupancy), 65'(DEPTH - 1));
        check("pp_ready", 65'(in_ready), 65'd1);
        drain();
        check("beat_count_33", 65'(beat_count), 65'd33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
